// File: rtl/audio_adc_rx_pkg.sv
// Shared definitions for the WM8731 ADC capture path: frame formats,
// receiver state encoding and the stereo word width helper.
package audio_adc_rx_pkg;

    // Frame format selectors for the I2S_MODE parameter
    localparam bit FMT_I2S = 1'b1;
    localparam bit FMT_LJ  = 1'b0;

    // Receiver lock state: IDLE until the first LRCK edge, then tracking channels
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } rx_state_e;

    // Width of one {left, right} stereo word
    function automatic int stereo_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/audio_adc_rx_if.sv
// Parallel output side of the ADC receiver: stereo word with valid/ready
// handshake plus the sticky overflow and frame-lock status flags.
interface audio_adc_rx_if #(
    parameter int DATA_W = 16
);
    import audio_adc_rx_pkg::*;

    logic [stereo_w(DATA_W)-1:0] data;
    logic                        valid;
    logic                        ready;
    logic                        ovf;
    logic                        sync;

    modport master (
        output data,
        output valid,
        output ovf,
        output sync,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  ovf,
        input  sync,
        output ready
    );

endinterface

// File: rtl/audio_adc_rx_sync_edge_det.sv
// Input conditioning for the codec pins: a plain 2-flop synchroniser and a
// synchroniser with a registered rising-edge pulse built on top of it.
module sync_2ff
    import audio_adc_rx_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next values of the two synchroniser stages
    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    // Two-stage metastability filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule

module sync_edge_det
    import audio_adc_rx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic sync_s;
    logic hist_q, hist_d;
    logic rise_q, rise_d;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (din),
        .dout (sync_s)
    );

    // Edge detect against the previous synchronised level
    always_comb begin
        hist_d = sync_s;
        rise_d = sync_s & ~hist_q;
    end

    // History flop and registered one-cycle rise pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/audio_adc_rx.sv
// WM8731 ADC serial receiver: oversamples BCLK/LRCK/DAT with iCLK,
// deserialises each channel MSB-first and presents {left, right} pairs
// through a single-entry valid/ready output register.
module audio_adc_rx
    import audio_adc_rx_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter bit I2S_MODE = FMT_I2S,
    parameter int TIMEOUT  = 1024
) (
    input  logic           iCLK,
    input  logic           iRST_N,
    input  logic           iAUD_BCLK,
    input  logic           iAUD_ADCLRCK,
    input  logic           iAUD_ADCDAT,
    audio_adc_rx_if.master aud
);

    localparam int   PAIR_W   = stereo_w(DATA_W);
    localparam int   CNT_W    = $clog2(DATA_W + 1);
    localparam int   TO_W     = $clog2(TIMEOUT);
    // LRCK level that marks the left channel in the selected format
    localparam logic LEFT_LVL = (I2S_MODE == FMT_I2S) ? 1'b0 : 1'b1;

    logic       rise;
    logic [1:0] lr_dat_s;
    logic       lr_s;
    logic       dat_s;

    rx_state_e          state_q, state_d;
    logic               lr_prev_q, lr_prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]  left_q, left_d;
    logic               have_left_q, have_left_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [PAIR_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;

    logic               chg;
    logic [DATA_W-1:0]  acc_word;
    logic [CNT_W-1:0]   acc_cnt;
    logic [DATA_W-1:0]  close_word;
    logic               pair_done;

    sync_edge_det u_bclk (
        .clk  (iCLK),
        .rst_n(iRST_N),
        .din  (iAUD_BCLK),
        .rise (rise)
    );

    sync_2ff #(.WIDTH(2)) u_lr_dat (
        .clk  (iCLK),
        .rst_n(iRST_N),
        .din  ({iAUD_ADCLRCK, iAUD_ADCDAT}),
        .dout (lr_dat_s)
    );

    assign lr_s  = lr_dat_s[1];
    assign dat_s = lr_dat_s[0];

    // Zero-fill below the n received bits so short words end up MSB-aligned
    function automatic logic [DATA_W-1:0] left_align(input logic [DATA_W-1:0] w,
                                                     input logic [CNT_W-1:0]  n);
        return w << (CNT_W'(DATA_W) - n);
    endfunction

    // Shift register contents if this rise's bit were accepted (saturating)
    always_comb begin
        chg = rise && (lr_s != lr_prev_q);
        if (cnt_q < CNT_W'(DATA_W)) begin
            acc_word = {shift_q[DATA_W-2:0], dat_s};
            acc_cnt  = cnt_q + CNT_W'(1);
        end else begin
            acc_word = shift_q;
            acc_cnt  = cnt_q;
        end
    end

    // Frame tracking: channel FSM, bit capture, word closing and loss-of-sync timeout
    always_comb begin
        state_d     = state_q;
        lr_prev_d   = lr_prev_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        left_d      = left_q;
        have_left_d = have_left_q;
        to_cnt_d    = to_cnt_q;
        close_word  = '0;
        pair_done   = 1'b0;

        if (rise) begin
            to_cnt_d  = '0;
            lr_prev_d = lr_s;
            if (chg) begin
                if (I2S_MODE == FMT_I2S) begin
                    close_word = left_align(acc_word, acc_cnt);
                    cnt_d      = '0;
                    shift_d    = '0;
                end else begin
                    close_word = left_align(shift_q, cnt_q);
                    cnt_d      = CNT_W'(1);
                    shift_d    = {{(DATA_W-1){1'b0}}, dat_s};
                end
                unique case (state_q)
                    ST_IDLE: begin
                        have_left_d = 1'b0;
                        state_d     = (lr_s == LEFT_LVL) ? ST_LEFT : ST_RIGHT;
                    end
                    ST_LEFT: begin
                        left_d      = close_word;
                        have_left_d = 1'b1;
                        state_d     = ST_RIGHT;
                    end
                    ST_RIGHT: begin
                        pair_done   = have_left_q;
                        have_left_d = 1'b0;
                        state_d     = ST_LEFT;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end else begin
                shift_d = acc_word;
                cnt_d   = acc_cnt;
            end
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            shift_d     = '0;
            have_left_d = 1'b0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Output register: accept a completed pair when free or draining, else flag overflow
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        if (valid_q && aud.ready) begin
            valid_d = 1'b0;
        end
        if (pair_done) begin
            if (!valid_q || aud.ready) begin
                data_d  = {left_q, close_word};
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_IDLE;
            lr_prev_q   <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            left_q      <= '0;
            have_left_q <= 1'b0;
            to_cnt_q    <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lr_prev_q   <= lr_prev_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            left_q      <= left_d;
            have_left_q <= have_left_d;
            to_cnt_q    <= to_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign aud.data  = data_q;
    assign aud.valid = valid_q;
    assign aud.ovf   = ovf_q;
    assign aud.sync  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_audio_adc_rx.sv
// Scoreboard bench for audio_adc_rx: one I2S and one left-justified
// receiver, each driven with directed serial frames; expected pairs are
// queued as frames are issued and popped by a monitor on each transfer.
module tb_audio_adc_rx;

    logic clk = 1'b0;
    logic rst_n;
    logic bclk_pin [2];
    logic lrck_pin [2];
    logic dat_pin  [2];

    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic [31:0] exp_word0;
    logic [31:0] exp_word1;
    logic [31:0] fl [4];
    logic [31:0] fr [4];

    int checks = 0;
    int errors = 0;

    // 10-unit system clock; BCLK is generated at 1/16 of this rate
    always #5 clk = ~clk;

    audio_adc_rx_if #(.DATA_W(16)) rx0 ();
    audio_adc_rx_if #(.DATA_W(16)) rx1 ();

    audio_adc_rx #(.DATA_W(16), .I2S_MODE(1'b1), .TIMEOUT(1024)) dut_i2s (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .iAUD_BCLK   (bclk_pin[0]),
        .iAUD_ADCLRCK(lrck_pin[0]),
        .iAUD_ADCDAT (dat_pin[0]),
        .aud         (rx0)
    );

    audio_adc_rx #(.DATA_W(16), .I2S_MODE(1'b0), .TIMEOUT(1024)) dut_lj (
        .iCLK        (clk),
        .iRST_N      (rst_n),
        .iAUD_BCLK   (bclk_pin[1]),
        .iAUD_ADCLRCK(lrck_pin[1]),
        .iAUD_ADCDAT (dat_pin[1]),
        .aud         (rx1)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor for the I2S receiver: every transfer must match the oldest queued pair
    always @(negedge clk) begin
        if (rst_n && rx0.valid && rx0.ready) begin
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pair_i2s: got %h, expected no transfer", rx0.data);
            end else begin
                exp_word0 = exp_q0.pop_front();
                check_output("pair_i2s", rx0.data, exp_word0);
            end
        end
    end

    // Monitor for the left-justified receiver
    always @(negedge clk) begin
        if (rst_n && rx1.valid && rx1.ready) begin
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pair_lj: got %h, expected no transfer", rx1.data);
            end else begin
                exp_word1 = exp_q1.pop_front();
                check_output("pair_lj", rx1.data, exp_word1);
            end
        end
    end

    // Hard bound on the whole run
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected run to complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // One BCLK period: data and LRCK change on the falling edge
    task automatic send_bit(input int inst, input logic lr, input logic d);
        bclk_pin[inst] = 1'b0;
        lrck_pin[inst] = lr;
        dat_pin[inst]  = d;
        #80;
        bclk_pin[inst] = 1'b1;
        #80;
    endtask

    // Bit k of a 32-slot channel carrying a len-bit word MSB-first
    function automatic logic slot_bit(input logic [31:0] w, input int len, input int k);
        if (k < len) return w[len-1-k];
        return 1'b0;
    endfunction

    task automatic send_channel(input int inst, input bit i2s, input logic lr,
                                input logic [31:0] w, input int len);
        for (int j = 0; j < 32; j++) begin
            if (i2s) begin
                if (j == 0) send_bit(inst, lr, 1'b0);
                else        send_bit(inst, lr, slot_bit(w, len, j - 1));
            end else begin
                send_bit(inst, lr, slot_bit(w, len, j));
            end
        end
    endtask

    // n frames from fl/fr, then one closing rise at the left-channel level
    task automatic apply_stimulus(input int inst, input bit i2s, input int len, input int n);
        logic left_lvl;
        left_lvl = i2s ? 1'b0 : 1'b1;
        for (int f = 0; f < n; f++) begin
            send_channel(inst, i2s, left_lvl, fl[f], len);
            send_channel(inst, i2s, ~left_lvl, fr[f], len);
        end
        send_bit(inst, left_lvl, 1'b0);
        bclk_pin[inst] = 1'b0;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            bclk_pin[i] = 1'b0;
            lrck_pin[i] = 1'b0;
            dat_pin[i]  = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain_check(input string name, input int inst);
        repeat (4) @(negedge clk);
        check_output(name, (inst == 0) ? exp_q0.size() : exp_q1.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bclk_pin[i] = 1'b0;
            lrck_pin[i] = 1'b0;
            dat_pin[i]  = 1'b0;
        end
        rx0.ready = 1'b1;
        rx1.ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        check_output("rst_data_i2s",  rx0.data,  32'd0);
        check_output("rst_valid_i2s", rx0.valid, 32'd0);
        check_output("rst_ovf_i2s",   rx0.ovf,   32'd0);
        check_output("rst_sync_i2s",  rx0.sync,  32'd0);
        check_output("rst_data_lj",   rx1.data,  32'd0);
        check_output("rst_valid_lj",  rx1.valid, 32'd0);
        check_output("rst_ovf_lj",    rx1.ovf,   32'd0);
        check_output("rst_sync_lj",   rx1.sync,  32'd0);

        $display("[TB] I2S 16-bit frames");
        fl[0] = 32'hFFFF; fr[0] = 32'hFFFF;
        fl[1] = 32'hA5C3; fr[1] = 32'h1234;
        fl[2] = 32'h5A3C; fr[2] = 32'hEDCB;
        exp_q0.push_back(32'hA5C31234);
        exp_q0.push_back(32'h5A3CEDCB);
        apply_stimulus(0, 1'b1, 16, 3);
        check_output("sync_i2s_locked", rx0.sync, 32'd1);
        drain_check("drain_i2s16", 0);
        check_output("ovf_i2s16", rx0.ovf, 32'd0);

        $display("[TB] left-justified 16-bit frames");
        fl[0] = 32'hA5C3; fr[0] = 32'h1234;
        fl[1] = 32'hC3A5; fr[1] = 32'h3412;
        exp_q1.push_back(32'hA5C31234);
        exp_q1.push_back(32'hC3A53412);
        apply_stimulus(1, 1'b0, 16, 2);
        check_output("sync_lj_locked", rx1.sync, 32'd1);
        drain_check("drain_lj16", 1);

        $display("[TB] I2S stream into left-justified receiver");
        do_reset();
        fl[0] = 32'hA5C3; fr[0] = 32'h1234;
        fl[1] = 32'hA5C3; fr[1] = 32'h1234;
        exp_q1.push_back(32'h091A52E1);
        apply_stimulus(1, 1'b1, 16, 2);
        drain_check("drain_lj_cross", 1);

        $display("[TB] I2S 12-bit words");
        do_reset();
        fl[0] = 32'hABC; fr[0] = 32'h123;
        fl[1] = 32'hABC; fr[1] = 32'h123;
        exp_q0.push_back(32'hABC01230);
        apply_stimulus(0, 1'b1, 12, 2);
        drain_check("drain_i2s12", 0);

        $display("[TB] I2S 24-bit words");
        do_reset();
        fl[0] = 32'h89ABCD; fr[0] = 32'h456789;
        fl[1] = 32'h89ABCD; fr[1] = 32'h456789;
        exp_q0.push_back(32'h89AB4567);
        apply_stimulus(0, 1'b1, 24, 2);
        drain_check("drain_i2s24", 0);

        $display("[TB] backpressure and overflow");
        do_reset();
        rx0.ready = 1'b0;
        fl[0] = 32'h1111; fr[0] = 32'h2222;
        fl[1] = 32'h3333; fr[1] = 32'h4444;
        fl[2] = 32'h5555; fr[2] = 32'h6666;
        exp_q0.push_back(32'h33334444);
        apply_stimulus(0, 1'b1, 16, 3);
        repeat (2) @(negedge clk);
        check_output("held_valid", rx0.valid, 32'd1);
        check_output("held_data",  rx0.data,  32'h33334444);
        check_output("ovf_set",    rx0.ovf,   32'd1);
        rx0.ready = 1'b1;
        repeat (6) @(negedge clk);
        check_output("ovf_sticky",    rx0.ovf,   32'd1);
        check_output("valid_cleared", rx0.valid, 32'd0);
        check_output("drain_ovf", exp_q0.size(), 32'd0);

        $display("[TB] reset mid left word");
        check_output("pre_rst_sync", rx0.sync, 32'd1);
        fl[0] = 32'hDEAD; fr[0] = 32'hBEEF;
        fl[1] = 32'hCAFE; fr[1] = 32'hF00D;
        fl[2] = 32'h1357; fr[2] = 32'h2468;
        exp_q0.push_back(32'hCAFEF00D);
        exp_q0.push_back(32'h13572468);
        fork
            apply_stimulus(0, 1'b1, 16, 3);
            begin
                repeat (200) @(negedge clk);
                #1 rst_n = 1'b0;
                #1;
                check_output("async_rst_data",  rx0.data,  32'd0);
                check_output("async_rst_valid", rx0.valid, 32'd0);
                check_output("async_rst_ovf",   rx0.ovf,   32'd0);
                check_output("async_rst_sync",  rx0.sync,  32'd0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        drain_check("drain_after_rst", 0);

        $display("[TB] loss of BCLK");
        check_output("sync_before_stall", rx0.sync, 32'd1);
        repeat (800) @(negedge clk);
        check_output("sync_during_stall", rx0.sync, 32'd1);
        repeat (300) @(negedge clk);
        check_output("sync_after_timeout", rx0.sync, 32'd0);
        check_output("no_pair_on_timeout", exp_q0.size(), 32'd0);
        fl[0] = 32'h7777; fr[0] = 32'h8888;
        fl[1] = 32'h9999; fr[1] = 32'hAAAA;
        exp_q0.push_back(32'h9999AAAA);
        apply_stimulus(0, 1'b1, 16, 2);
        drain_check("drain_resume", 0);
        check_output("ovf_after_resume", rx0.ovf, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
